// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program-ROM loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  function automatic int unsigned bytes_per_word(input int unsigned word_bits);
    return (word_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and ROM write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned WORD_BITS = 48,
  parameter int unsigned ADDR_BITS = 11
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 rom_we;
  logic [ADDR_BITS-1:0] rom_addr;
  logic [WORD_BITS-1:0] rom_data;

  // master: stream source / ROM observer; slave: the loader
  modport master (
    output in_data, in_valid,
    input  in_ready, rom_we, rom_addr, rom_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs MSB-first bytes into WORD_BITS-wide words; flags the byte that completes a word.
module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_BITS = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_complete
);
  localparam int unsigned Bytes = bytes_per_word(WORD_BITS);
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  logic [WORD_BITS-1:0] shreg_q;
  logic [CntW-1:0]      cnt_q;

  // Truncation drops the unused high bits of the first byte when WORD_BITS%8 != 0.
  always_comb begin
    word          = WORD_BITS'({shreg_q, byte_in});
    word_complete = byte_valid && (cnt_q == CntW'(Bytes - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shreg_q <= word;
      cnt_q   <= word_complete ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream ROM loader: length, packed data words, checksum; gates CPU reset and
// watches the PC against the loaded program length.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_BITS = 48,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned PC_BITS   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  prog_loader_if.slave       bus,
  output logic               _cpu_reset,
  output logic               done,
  output logic [1:0]         err,
  output logic [ADDR_BITS:0] prog_len,
  input  logic [PC_BITS-1:0] pc,
  output logic               pc_oob
);
  localparam int unsigned Depth = 2 ** ADDR_BITS;

  state_e               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           sum_q, sum_d;
  logic [ADDR_BITS:0]   idx_q, idx_d;
  logic                 rom_we_q, rom_we_d;
  logic [ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic [WORD_BITS-1:0] rom_data_q, rom_data_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic [ADDR_BITS:0]   prog_len_q, prog_len_d;
  logic                 pc_oob_q, pc_oob_d;

  logic                 accept;
  logic                 start_ok;
  logic                 pack_valid;
  logic [WORD_BITS-1:0] pack_word;
  logic                 pack_done;
  logic [15:0]          len_full;
  logic [7:0]           csum_total;

  always_comb begin
    bus.in_ready = (state_q inside {StLenLo, StLenHi, StData, StCsum}) && !rom_we_q;
    accept       = bus.in_valid && bus.in_ready;
    start_ok     = start && (state_q inside {StIdle, StDone, StError});
    pack_valid   = accept && (state_q == StData);
    len_full     = {bus.in_data, len_q[7:0]};
    csum_total   = sum_q + bus.in_data;
  end

  byte_packer #(
    .WORD_BITS(WORD_BITS)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .byte_valid   (pack_valid),
    .byte_in      (bus.in_data),
    .word         (pack_word),
    .word_complete(pack_done)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    prog_len_d  = prog_len_q;
    pc_oob_d    = pc_oob_q;

    if (start_ok) begin
      state_d     = StLenLo;
      err_d       = ERR_NONE;
      done_d      = 1'b0;
      pc_oob_d    = 1'b0;
      sum_d       = '0;
      idx_d       = '0;
      cpu_rst_n_d = 1'b0;
    end else begin
      unique case (state_q)
        StLenLo: begin
          if (accept) begin
            len_d   = {8'h00, bus.in_data};
            state_d = StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_d = len_full;
            if (len_full == 16'd0 || 32'(len_full) > Depth) begin
              state_d = StError;
              err_d   = ERR_LEN;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            sum_d = csum_total;
          end
          if (pack_done) begin
            rom_we_d   = 1'b1;
            rom_addr_d = idx_q[ADDR_BITS-1:0];
            rom_data_d = pack_word;
            idx_d      = idx_q + 1'b1;
            if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
              state_d = StCsum;
            end
          end
        end
        StCsum: begin
          if (accept) begin
            if (csum_total == 8'h00) begin
              state_d     = StDone;
              prog_len_d  = len_q[ADDR_BITS:0];
              done_d      = 1'b1;
              cpu_rst_n_d = 1'b1;
            end else begin
              state_d    = StError;
              err_d      = ERR_CSUM;
              prog_len_d = '0;
            end
          end
        end
        StDone: begin
          if (32'(pc) >= 32'(prog_len_q)) begin
            pc_oob_d = 1'b1;
          end
        end
        default: ;  // StIdle, StError wait for start
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
      prog_len_q  <= '0;
      pc_oob_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
      prog_len_q  <= prog_len_d;
      pc_oob_q    <= pc_oob_d;
    end
  end

  always_comb begin
    bus.rom_we   = rom_we_q;
    bus.rom_addr = rom_addr_q;
    bus.rom_data = rom_data_q;
    _cpu_reset   = cpu_rst_n_q;
    done         = done_q;
    err          = err_q;
    prog_len     = prog_len_q;
    pc_oob       = pc_oob_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, length/checksum errors, PC monitor, reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc = 16'd0;
  logic        cpu_reset_n;
  logic        done;
  logic [1:0]  err;
  logic [11:0] prog_len;
  logic        pc_oob;

  logic [47:0] rom [2048];
  int          we_cnt = 0;
  int          total = 0;
  int          bad = 0;

  prog_loader_if #(.WORD_BITS(48), .ADDR_BITS(11)) bus ();

  prog_loader #(
    .WORD_BITS(48),
    .ADDR_BITS(11),
    .PC_BITS  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    ._cpu_reset(cpu_reset_n),
    .done      (done),
    .err       (err),
    .prog_len  (prog_len),
    .pc        (pc),
    .pc_oob    (pc_oob)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      rom[bus.rom_addr] = bus.rom_data;
      we_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Two-word frame with data bytes 01..0C; optional idle gaps and a start pulse mid-DATA.
  task automatic send_frame(input logic [7:0] csum, input bit gaps);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i));
      if (gaps) begin
        if (i == 5) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    send_byte(csum);
  endtask

  task automatic clear_rom();
    rom[0] = '0;
    rom[1] = '0;
  endtask

  task automatic check_good(input string tag, input int we_base);
    check({tag, "_w0"}, 64'(rom[0]), 64'h0000_0102_0304_0506);
    check({tag, "_w1"}, 64'(rom[1]), 64'h0000_0708_090A_0B0C);
    check({tag, "_wecnt"}, 64'(we_cnt - we_base), 64'd2);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_len"}, 64'(prog_len), 64'd2);
    check({tag, "_cpurst"}, 64'(cpu_reset_n), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_we", 64'(bus.rom_we), 64'd0);
    check("rst_addr", 64'(bus.rom_addr), 64'd0);
    check("rst_data", 64'(bus.rom_data), 64'd0);
    check("rst_cpurst", 64'(cpu_reset_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_len", 64'(prog_len), 64'd0);
    check("rst_oob", 64'(pc_oob), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: good load
    clear_rom();
    base = we_cnt;
    pulse_start();
    check("t1_ready_lenlo", 64'(bus.in_ready), 64'd1);
    send_frame(8'hB2, 1'b0);
    check_good("t1", base);

    // 2: bad checksum
    clear_rom();
    base = we_cnt;
    pulse_start();
    check("t2_cpurst_start", 64'(cpu_reset_n), 64'd0);
    check("t2_done_start", 64'(done), 64'd0);
    send_frame(8'hB3, 1'b0);
    check("t2_err", 64'(err), 64'd2);
    check("t2_done", 64'(done), 64'd0);
    check("t2_cpurst", 64'(cpu_reset_n), 64'd0);
    check("t2_len", 64'(prog_len), 64'd0);
    check("t2_wecnt", 64'(we_cnt - base), 64'd2);
    check("t2_w1_kept", 64'(rom[1]), 64'h0000_0708_090A_0B0C);

    // 3: length errors
    base = we_cnt;
    pulse_start();
    check("t3_err_clr", 64'(err), 64'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t3_err_len0", 64'(err), 64'd1);
    check("t3_ready_err", 64'(bus.in_ready), 64'd0);
    pulse_start();
    check("t3_err_clr2", 64'(err), 64'd0);
    send_byte(8'h01);
    send_byte(8'h08);
    check("t3_err_2049", 64'(err), 64'd1);
    check("t3_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("t3_wecnt", 64'(we_cnt - base), 64'd0);

    // 4: gapped stream with an ignored start mid-DATA
    clear_rom();
    base = we_cnt;
    pulse_start();
    send_frame(8'hB2, 1'b1);
    check_good("t4", base);

    // 5: PC monitor
    pc = 16'd1;
    repeat (2) @(negedge clk);
    check("t5_pc1", 64'(pc_oob), 64'd0);
    pc = 16'd2;
    @(negedge clk);
    check("t5_pc2", 64'(pc_oob), 64'd1);
    pc = 16'd0;
    repeat (2) @(negedge clk);
    check("t5_sticky", 64'(pc_oob), 64'd1);
    pulse_start();
    check("t5_clr", 64'(pc_oob), 64'd0);
    check("t5_cpurst", 64'(cpu_reset_n), 64'd0);

    // 6: reset during DATA after 3 bytes, then a full load
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_ready", 64'(bus.in_ready), 64'd0);
    check("t6_cpurst", 64'(cpu_reset_n), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_len", 64'(prog_len), 64'd0);
    check("t6_we", 64'(bus.rom_we), 64'd0);
    clear_rom();
    base = we_cnt;
    pulse_start();
    send_frame(8'hB2, 1'b0);
    check_good("t6", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
